frame_update_sequencer: RTL and testbench

//  Per-frame controller for the game-logic datapath. On each frame_start pulse it:
//   1. advances game time;
//   2. kicks block_loader and waits for its done;
//   3. kicks block_positions and waits for its done;
//   4. raises block_position_ready so game_state and renderer consume a consistent snapshot.

---
 rtl/frame_update_sequencer.sv | 158 +++++++++++++++
 tb/tb_frame_update_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_sequencer.sv
// Per-frame sequencer: advances game time, runs block_loader then block_positions,
// and publishes a consistent-snapshot flag. It also counts dropped frame starts and flags hung stages.
module frame_update_sequencer #(
  parameter int unsigned TIME_STEP      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic [1:0]  state_in,
  input  logic [17:0] max_time_in,
  input  logic        load_done_in,
  input  logic        pos_done_in,
  output logic [17:0] curr_time_out,
  output logic        load_start_out,
  output logic        pos_start_out,
  output logic        block_position_ready_out,
  output logic        frame_done_out,
  output logic [15:0] frame_count_out,
  output logic [7:0]  overrun_count_out,
  output logic        timeout_out
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [18:0]      STEP_19  = 19'(TIME_STEP);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TICK      = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_LOAD = 3'd3,
    ST_POS       = 3'd4,
    ST_WAIT_POS  = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             timeout_hit_s;
  logic             frame_ok_s;
  logic             wait_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [17:0]      curr_time_r;
  logic             ready_r;
  logic [15:0]      frame_count_r;
  logic [7:0]       overrun_count_r;
  logic             timeout_r;

  // The sum is formed in 19 bits so a step past 2^18-1 still clamps to the limit.
  function automatic logic [17:0] next_time(input logic [1:0]  game_state,
                                            input logic [17:0] now,
                                            input logic [17:0] limit);
    logic [18:0] sum;
    sum = {1'b0, now} + STEP_19;
    case (game_state)
      2'b00:   next_time = 18'd0;
      2'b01:   next_time = (sum > {1'b0, limit}) ? limit : sum[17:0];
      default: next_time = now;
    endcase
  endfunction

  // Next-state decode, including the per-stage watchdog abort.
  always_comb begin
    state_s       = state_r;
    timeout_hit_s = 1'b0;
    frame_ok_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_start_in) state_s = ST_TICK;
        else                state_s = ST_IDLE;
      end
      ST_TICK: state_s = ST_LOAD;
      ST_LOAD: state_s = ST_WAIT_LOAD;
      ST_WAIT_LOAD: begin
        if (load_done_in) begin
          state_s = ST_POS;
        end else if (wait_cnt_r == CNT_LAST) begin
          state_s       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_WAIT_LOAD;
        end
      end
      ST_POS: state_s = ST_WAIT_POS;
      ST_WAIT_POS: begin
        if (pos_done_in) begin
          state_s    = ST_DONE;
          frame_ok_s = 1'b1;
        end else if (wait_cnt_r == CNT_LAST) begin
          state_s       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_WAIT_POS;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign wait_s = (state_r == ST_WAIT_LOAD) || (state_r == ST_WAIT_POS);

  // State register and wait-cycle counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_LOAD) || (state_r == ST_POS)) begin
        wait_cnt_r <= '0;
      end else if (wait_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Game time, snapshot flag and status counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      curr_time_r     <= 18'd0;
      ready_r         <= 1'b0;
      frame_count_r   <= 16'd0;
      overrun_count_r <= 8'd0;
      timeout_r       <= 1'b0;
    end else begin
      if (state_r == ST_TICK) begin
        curr_time_r <= next_time(state_in, curr_time_r, max_time_in);
        ready_r     <= 1'b0;
      end else if (frame_ok_s) begin
        ready_r <= 1'b1;
      end
      if (frame_ok_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
      if (frame_start_in && (state_r != ST_IDLE) && (overrun_count_r != 8'hFF)) begin
        overrun_count_r <= overrun_count_r + 8'd1;
      end
      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign load_start_out           = (state_r == ST_LOAD);
  assign pos_start_out            = (state_r == ST_POS);
  assign frame_done_out           = (state_r == ST_DONE);
  assign curr_time_out            = curr_time_r;
  assign block_position_ready_out = ready_r;
  assign frame_count_out          = frame_count_r;
  assign overrun_count_out        = overrun_count_r;
  assign timeout_out              = timeout_r;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Self-checking bench for frame_update_sequencer: randomized frames checked against a
// frame-level timing/arithmetic model.
module tb_frame_update_sequencer;
  localparam int STEP = 5;
  localparam int TMO  = 4096;

  logic        clk_in = 1'b0;
  logic        rst_in, frame_start_in, load_done_in, pos_done_in;
  logic [1:0]  state_in;
  logic [17:0] max_time_in;
  logic [17:0] curr_time_out;
  logic        load_start_out, pos_start_out, block_position_ready_out, frame_done_out;
  logic [15:0] frame_count_out;
  logic [7:0]  overrun_count_out;
  logic        timeout_out;

  int tests = 0, fails = 0, cyc = 0;
  int m_time = 0, m_fc = 0, m_ovr = 0, m_to = 0;

  frame_update_sequencer #(.TIME_STEP(STEP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .state_in(state_in), .max_time_in(max_time_in), .load_done_in(load_done_in),
    .pos_done_in(pos_done_in), .curr_time_out(curr_time_out),
    .load_start_out(load_start_out), .pos_start_out(pos_start_out),
    .block_position_ready_out(block_position_ready_out), .frame_done_out(frame_done_out),
    .frame_count_out(frame_count_out), .overrun_count_out(overrun_count_out),
    .timeout_out(timeout_out));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int model_time(int st, int now, int mx);
    if (st == 0) return 0;
    if (st == 1) return (now + STEP > mx) ? mx : now + STEP;
    return now;
  endfunction

  // One complete frame; done pulses dl/dp cycles after each start strobe, frame_start
  // re-pulsed for ex_len cycles starting ex_off cycles after the accepted one.
  task automatic run_frame(input int st, input int mx, input int dl, input int dp,
                           input bit hold_load, input int ex_off, input int ex_len);
    int n, t_ls, t_ps, t_fd, exp_t, eff_dl;
    logic [17:0] ls_time, fd_time;
    logic        ls_ready, fd_ready, fd_to;
    logic [15:0] fd_fc;
    logic [7:0]  fd_ovr;
    t_ls = -1; t_ps = -1; t_fd = -1;
    ls_time = 'x; ls_ready = 'x; fd_time = 'x; fd_ready = 'x; fd_to = 'x; fd_fc = 'x; fd_ovr = 'x;
    eff_dl = (dl < 1) ? 1 : dl;
    state_in = 2'(st);
    max_time_in = 18'(mx);
    exp_t = model_time(st, m_time, mx);
    n = cyc;
    frame_start_in = 1'b1;
    for (int k = 0; k < 800 && t_fd < 0; k++) begin
      step();
      frame_start_in = (ex_len > 0) && (cyc >= n + ex_off) && (cyc < n + ex_off + ex_len);
      if (load_start_out && t_ls < 0) begin
        t_ls = cyc; ls_time = curr_time_out; ls_ready = block_position_ready_out;
      end
      if (pos_start_out && t_ps < 0) t_ps = cyc;
      if (frame_done_out && t_fd < 0) begin
        t_fd = cyc; fd_time = curr_time_out; fd_ready = block_position_ready_out;
        fd_fc = frame_count_out; fd_ovr = overrun_count_out; fd_to = timeout_out;
      end
      load_done_in = (t_ls >= 0) && (t_ps < 0) &&
                     (hold_load ? (cyc >= t_ls + dl) : (cyc == t_ls + dl));
      pos_done_in = (t_ps >= 0) && (t_fd < 0) && (cyc == t_ps + dp);
      if (t_ls >= 0 && t_fd < 0) begin
        state_in = 2'($urandom);
        max_time_in = 18'($urandom);
      end
    end
    frame_start_in = 1'b0; load_done_in = 1'b0; pos_done_in = 1'b0;
    m_fc  = (m_fc + 1) % 65536;
    m_ovr = (m_ovr + ex_len > 255) ? 255 : m_ovr + ex_len;
    m_time = exp_t;
    tests++; if (t_fd < 0) begin fails++; $display("FAIL frame_bound: no frame_done within 800 cycles"); end
    tests++; if (t_ls !== n + 2) begin fails++; $display("FAIL load_start_lat: got cyc %0d want %0d", t_ls, n + 2); end
    tests++; if (ls_time !== 18'(exp_t)) begin fails++; $display("FAIL curr_time: got %0d want %0d", ls_time, exp_t); end
    tests++; if (ls_ready !== 1'b0) begin fails++; $display("FAIL ready_clear: got %b want 0", ls_ready); end
    tests++; if (t_ps !== t_ls + eff_dl + 1) begin fails++; $display("FAIL pos_start_lat: got cyc %0d want %0d", t_ps, t_ls + eff_dl + 1); end
    tests++; if (t_fd !== t_ps + dp + 1) begin fails++; $display("FAIL frame_done_lat: got cyc %0d want %0d", t_fd, t_ps + dp + 1); end
    tests++; if (fd_ready !== 1'b1 || fd_time !== 18'(exp_t)) begin fails++; $display("FAIL ready_snapshot: got ready %b time %0d want 1 %0d", fd_ready, fd_time, exp_t); end
    tests++; if (fd_fc !== 16'(m_fc)) begin fails++; $display("FAIL frame_count: got %0d want %0d", fd_fc, m_fc); end
    tests++; if (fd_ovr !== 8'(m_ovr)) begin fails++; $display("FAIL overrun_count: got %0d want %0d", fd_ovr, m_ovr); end
    tests++; if (fd_to !== 1'(m_to)) begin fails++; $display("FAIL timeout_flag: got %b want %0d", fd_to, m_to); end
    step();
    tests++;
    if (frame_done_out !== 1'b0 || block_position_ready_out !== 1'b1 || load_start_out !== 1'b0) begin
      fails++; $display("FAIL after_done: got done %b ready %b load %b want 0 1 0",
                        frame_done_out, block_position_ready_out, load_start_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; frame_start_in = 1'b0; load_done_in = 1'b0; pos_done_in = 1'b0;
    state_in = 2'b01; max_time_in = 18'd1000;
    step(); step();
    tests++;
    if ({curr_time_out, load_start_out, pos_start_out, block_position_ready_out, frame_done_out,
         frame_count_out, overrun_count_out, timeout_out} !== '0) begin
      fails++; $display("FAIL reset_outputs: got time %0d fc %0d ovr %0d to %b want all 0",
                        curr_time_out, frame_count_out, overrun_count_out, timeout_out);
    end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_basic();
    run_frame(1, 1000, 3, 3, 1'b0, 0, 0);
    run_frame(1, 1000, 1, 1, 1'b0, 0, 0);
    run_frame(1, 1000, 0, 2, 1'b1, 0, 0);
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 200; i++) run_frame(1, 999, 1, 1, 1'b0, 0, 0);
    tests++; if (curr_time_out !== 18'd999) begin fails++; $display("FAIL clamp_999: got %0d want 999", curr_time_out); end
    run_frame(1, 1000, 1, 1, 1'b0, 0, 0);
    run_frame(1, 1000, 2, 1, 1'b0, 0, 0);
    tests++; if (curr_time_out !== 18'd1000) begin fails++; $display("FAIL clamp_1000: got %0d want 1000", curr_time_out); end
    run_frame(1, 400, 1, 1, 1'b0, 0, 0);
  endtask

  task automatic test_pause_menu();
    run_frame(2, 1000, 2, 2, 1'b0, 0, 0);
    run_frame(3, 1000, 1, 3, 1'b0, 0, 0);
    run_frame(0, 1000, 1, 1, 1'b0, 0, 0);
    tests++; if (curr_time_out !== 18'd0) begin fails++; $display("FAIL menu_zero: got %0d want 0", curr_time_out); end
  endtask

  task automatic test_overrun();
    run_frame(1, 1000, 3, 3, 1'b0, 2, 1);
    tests++; if (overrun_count_out !== 8'd1) begin fails++; $display("FAIL overrun_one: got %0d want 1", overrun_count_out); end
    run_frame(1, 1000, 300, 1, 1'b0, 1, 300);
    run_frame(1, 1000, 2, 1, 1'b0, 1, 2);
    tests++; if (overrun_count_out !== 8'd255) begin fails++; $display("FAIL overrun_sat: got %0d want 255", overrun_count_out); end
  endtask

  task automatic test_timeout();
    int t_ls, t_to, exp_t;
    logic to_before, saw_ps, saw_fd, ready_at, idle_ok;
    logic [15:0] fc_at;
    logic [17:0] time_at;
    t_ls = -1; t_to = -1; to_before = 'x; saw_ps = 1'b0; saw_fd = 1'b0;
    ready_at = 'x; fc_at = 'x; time_at = 'x;
    state_in = 2'b01; max_time_in = 18'd5000;
    exp_t = model_time(1, m_time, 5000);
    frame_start_in = 1'b1;
    for (int k = 0; k < TMO + 50 && t_to < 0; k++) begin
      step();
      frame_start_in = 1'b0;
      if (load_start_out && t_ls < 0) t_ls = cyc;
      if (pos_start_out) saw_ps = 1'b1;
      if (frame_done_out) saw_fd = 1'b1;
      if (t_ls >= 0 && cyc == t_ls + TMO) to_before = timeout_out;
      if (timeout_out && t_to < 0) begin
        t_to = cyc; ready_at = block_position_ready_out; fc_at = frame_count_out; time_at = curr_time_out;
      end
    end
    m_time = exp_t; m_to = 1;
    tests++; if (t_ls < 0 || t_to !== t_ls + TMO + 1) begin fails++; $display("FAIL timeout_lat: got cyc %0d want %0d", t_to, t_ls + TMO + 1); end
    tests++; if (to_before !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b want 0", to_before); end
    tests++; if (saw_ps || saw_fd) begin fails++; $display("FAIL timeout_strobes: got pos %b done %b want 0 0", saw_ps, saw_fd); end
    tests++;
    if (ready_at !== 1'b0 || fc_at !== 16'(m_fc) || time_at !== 18'(exp_t)) begin
      fails++; $display("FAIL timeout_state: got ready %b fc %0d time %0d want 0 %0d %0d", ready_at, fc_at, time_at, m_fc, exp_t);
    end
    idle_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (timeout_out !== 1'b1 || load_start_out !== 1'b0 || pos_start_out !== 1'b0) idle_ok = 1'b0;
    end
    tests++; if (idle_ok !== 1'b1) begin fails++; $display("FAIL timeout_idle: got %b want 1", idle_ok); end
    run_frame(1, 5000, 2, 2, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int st, mx, dl, dp, exl;
    bit hold;
    for (int i = 0; i < 25; i++) begin
      st = $urandom_range(0, 3);
      mx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3000);
      dl = $urandom_range(0, 6);
      hold = (dl == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dp = $urandom_range(1, 5);
      exl = $urandom_range(0, dl + 1);
      run_frame(st, mx, dl, dp, hold, 1, exl);
    end
  endtask

  task automatic test_reset_mid();
    int t_ls, t_ps;
    logic quiet;
    t_ls = -1; t_ps = -1;
    state_in = 2'b01; max_time_in = 18'd1000;
    frame_start_in = 1'b1;
    for (int k = 0; k < 50 && t_ps < 0; k++) begin
      step();
      frame_start_in = 1'b0;
      if (load_start_out && t_ls < 0) t_ls = cyc;
      if (pos_start_out) t_ps = cyc;
      load_done_in = (t_ls >= 0) && (t_ps < 0) && (cyc == t_ls + 1);
    end
    load_done_in = 1'b0;
    tests++; if (t_ps < 0) begin fails++; $display("FAIL rst_mid_setup: got no pos_start want pos_start"); end
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    tests++;
    if ({curr_time_out, load_start_out, pos_start_out, block_position_ready_out, frame_done_out,
         frame_count_out, overrun_count_out, timeout_out} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: got time %0d fc %0d ovr %0d to %b ready %b want all 0",
                        curr_time_out, frame_count_out, overrun_count_out, timeout_out, block_position_ready_out);
    end
    m_time = 0; m_fc = 0; m_ovr = 0; m_to = 0;
    pos_done_in = 1'b1;
    step();
    pos_done_in = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (frame_done_out || pos_start_out || load_start_out || block_position_ready_out ||
          frame_count_out != 16'd0) quiet = 1'b0;
      step();
    end
    tests++; if (quiet !== 1'b1) begin fails++; $display("FAIL rst_mid_late_done: got %b want 1", quiet); end
    run_frame(1, 1000, 2, 2, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_pause_menu();
    test_overrun();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
